// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A value is accepted on Start while idle and converted over BIN_W cycles.
// The packed BCD result and its overflow flag are held until the next
// completion. One selected digit is exposed for a downstream BCD decoder.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [BIN_W-1:0]      BinIn,
    input  logic [3:0]            DigitSel,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCDOut,
    output logic                  Overflow,
    output logic [3:0]            BCDDigit
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovfSticky;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcdOut;
    logic               r_overflow;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_bcdNext;
    logic [BIN_W-1:0]   w_binNext;
    logic               w_carryOut;
    logic [3:0]         w_digit;

    // Add 3 to every working digit of 5 or more so the following shift carries correctly into the next digit
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit means the true value needs more digits than we keep
    assign w_carryOut = w_adj[BCD_W-1];
    assign w_bcdNext  = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
    assign w_binNext  = r_bin << 1;

    // Control FSM and datapath; all visible outputs are registered here
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_ovfSticky <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bcdOut    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_bin       <= BinIn;
                        r_bcd       <= '0;
                        r_ovfSticky <= 1'b0;
                        r_cnt       <= CNT_W'(BIN_W);
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd       <= w_bcdNext;
                    r_bin       <= w_binNext;
                    r_ovfSticky <= r_ovfSticky | w_carryOut;
                    r_cnt       <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcdOut   <= w_bcdNext;
                        r_overflow <= r_ovfSticky | w_carryOut;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Digit select; an out-of-range index yields 4'hF so the downstream decoder shows nothing
    always_comb begin
        w_digit = 4'hF;
        for (int i = 0; i < DIGITS; i++) begin
            if (DigitSel == 4'(i)) begin
                w_digit = r_bcdOut[4*i +: 4];
            end
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign BCDOut   = r_bcdOut;
    assign Overflow = r_overflow;
    assign BCDDigit = w_digit;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Two instances share all inputs:
// the default 3-digit build and a 2-digit build that exercises overflow.
// Expected results come from a decimal reference model and are queued when
// a conversion is started, then popped and compared when Done rises.
module tb_bin_to_bcd_seq;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic [7:0]  BinIn;
    logic [3:0]  DigitSel;

    logic        Busy, Done, Overflow;
    logic [11:0] BCDOut;
    logic [3:0]  BCDDigit;

    logic        Busy2, Done2, Overflow2;
    logic [7:0]  BCDOut2;
    logic [3:0]  BCDDigit2;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } exp_t;

    exp_t sbQ[$];

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .BinIn(BinIn), .DigitSel(DigitSel),
        .Busy(Busy), .Done(Done), .BCDOut(BCDOut), .Overflow(Overflow), .BCDDigit(BCDDigit)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .CLK(CLK), .RST(RST), .Start(Start), .BinIn(BinIn), .DigitSel(DigitSel),
        .Busy(Busy2), .Done(Done2), .BCDOut(BCDOut2), .Overflow(Overflow2), .BCDDigit(BCDDigit2)
    );

    // Free-running clock, period 10
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decimal reference: low `digits` decimal digits of v, packed BCD
    function automatic logic [15:0] refBcd(input int unsigned v, input int digits);
        logic [15:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic refOvf(input int unsigned v, input int digits);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive Start for one edge with value v and queue the model result
    task automatic applyStimulus(input int unsigned v);
        exp_t e;
        e.bcd3 = refBcd(v, 3)[11:0];
        e.ovf3 = refOvf(v, 3);
        e.bcd2 = refBcd(v, 2)[7:0];
        e.ovf2 = refOvf(v, 2);
        sbQ.push_back(e);
        Start = 1'b1;
        BinIn = 8'(v);
        tick();
        Start = 1'b0;
    endtask

    // Bounded wait for Done; checks latency, Busy length and the queued result
    task automatic waitDone(input string tag, input int expCycles);
        int cycles;
        int busyCycles;
        exp_t e;
        cycles = 0;
        busyCycles = 0;
        while (Done !== 1'b1 && cycles < 40) begin
            if (Busy === 1'b1) busyCycles++;
            tick();
            cycles++;
        end
        checkOutput({tag, "-latency"}, cycles, expCycles);
        checkOutput({tag, "-busyLen"}, busyCycles, expCycles);
        checkOutput({tag, "-done2"}, {31'd0, Done2}, 32'd1);
        checkOutput({tag, "-sbDepth"}, sbQ.size(), 1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, "-bcd3"}, {20'd0, BCDOut}, {20'd0, e.bcd3});
            checkOutput({tag, "-ovf3"}, {31'd0, Overflow}, {31'd0, e.ovf3});
            checkOutput({tag, "-bcd2"}, {24'd0, BCDOut2}, {24'd0, e.bcd2});
            checkOutput({tag, "-ovf2"}, {31'd0, Overflow2}, {31'd0, e.ovf2});
        end
    endtask

    // Directed sequence followed by a full sweep of the 8-bit input range
    initial begin
        int doneSeen;
        RST      = 1'b1;
        Start    = 1'b0;
        BinIn    = 8'd0;
        DigitSel = 4'd0;
        #1;
        checkOutput("rst-busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst-done", {31'd0, Done}, 32'd0);
        checkOutput("rst-bcd", {20'd0, BCDOut}, 32'd0);
        checkOutput("rst-ovf", {31'd0, Overflow}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // 255: full result, digit mux and one-cycle Done
        applyStimulus(255);
        checkOutput("c255-busyAfterStart", {31'd0, Busy}, 32'd1);
        waitDone("c255", 8);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] expDigit;
            DigitSel = 4'(s);
            #1;
            expDigit = (s == 0) ? 4'd5 : (s == 1) ? 4'd5 : (s == 2) ? 4'd2 : 4'hF;
            checkOutput($sformatf("digit%0d", s), {28'd0, BCDDigit}, {28'd0, expDigit});
            if (s == 0) checkOutput("digit2-sel0", {28'd0, BCDDigit2}, 32'd5);
            if (s == 2) checkOutput("digit2-sel2", {28'd0, BCDDigit2}, 32'hF);
        end
        DigitSel = 4'd0;
        tick();
        checkOutput("c255-donePulse", {31'd0, Done}, 32'd0);

        // Smallest values
        applyStimulus(0);
        waitDone("c0", 8);
        tick();
        applyStimulus(9);
        waitDone("c9", 8);
        tick();

        // Start while busy ignored, then Start accepted in the Done cycle
        applyStimulus(100);
        tick();
        tick();
        Start = 1'b1;
        BinIn = 8'd7;
        tick();
        Start = 1'b0;
        waitDone("c100", 5);
        applyStimulus(42);
        checkOutput("c42-doneDrop", {31'd0, Done}, 32'd0);
        checkOutput("c42-busyRise", {31'd0, Busy}, 32'd1);
        checkOutput("c42-holdBcd", {20'd0, BCDOut}, 32'h100);
        checkOutput("c42-holdOvf2", {31'd0, Overflow2}, 32'd1);
        waitDone("c42", 8);
        tick();
        checkOutput("c42-holdAfter", {20'd0, BCDOut}, 32'h042);

        // Reset in mid-conversion discards it
        applyStimulus(200);
        tick();
        tick();
        tick();
        RST = 1'b1;
        #1;
        checkOutput("midrst-busy", {31'd0, Busy}, 32'd0);
        checkOutput("midrst-done", {31'd0, Done}, 32'd0);
        checkOutput("midrst-bcd", {20'd0, BCDOut}, 32'd0);
        checkOutput("midrst-ovf", {31'd0, Overflow}, 32'd0);
        tick();
        RST = 1'b0;
        sbQ.delete();
        doneSeen = 0;
        for (int c = 0; c < 12; c++) begin
            if (Done === 1'b1) doneSeen++;
            tick();
        end
        checkOutput("midrst-noDone", doneSeen, 0);
        applyStimulus(123);
        waitDone("c123", 8);
        tick();

        // 2-digit instance at its limit
        applyStimulus(99);
        waitDone("c99", 8);
        tick();

        // Sweep, each new Start issued in the previous Done cycle
        for (int v = 0; v < 256; v++) begin
            applyStimulus(v);
            waitDone($sformatf("sweep%0d", v), 8);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
